// File: rtl/popcnt_share_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : popcnt_share_ctrl_pkg
// Brief    : Shared FSM encoding and popcount-unit constants
// Revision : 1.0
// ============================================================================
package popcnt_share_ctrl_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Cycles from pc_start until the unit raises pc_vld with a valid result
    localparam int c_PC_LATENCY = 5;
    localparam int c_RES_W      = 5;

endpackage : popcnt_share_ctrl_pkg
`default_nettype wire

// File: rtl/popcnt_share_ctrl_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_onehot
// Brief    : Combinational round-robin pick, first set bit at or after ptr
// Revision : 1.0
// ============================================================================
module rr_arbiter_onehot #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    localparam logic [IW:0] c_N = (IW+1)'(N);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_pos;

    // Walk N candidates starting at ptr, wrapping modulo N
    always_comb begin
        gnt   = '0;
        idx   = '0;
        any   = 1'b0;
        w_sum = '0;
        w_pos = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, ptr} + k[IW:0];
            if (w_sum >= c_N) begin
                w_sum = w_sum - c_N;
            end
            w_pos = w_sum[IW-1:0];
            if (!any && req[w_pos]) begin
                any        = 1'b1;
                idx        = w_pos;
                gnt[w_pos] = 1'b1;
            end
        end
    end

endmodule : rr_arbiter_onehot
`default_nettype wire

// File: rtl/popcnt_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : popcnt_share_ctrl
// Brief    : Time-shares one external popcount unit among NUM_REQ requesters
// Revision : 1.0
// ============================================================================
module popcnt_share_ctrl
    import popcnt_share_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic [c_RES_W-1:0]   result,
    output logic                 err,
    output logic                 busy,
    output logic                 pc_start,
    output logic [DW-1:0]        pc_din,
    input  logic                 pc_vld,
    input  logic [c_RES_W-1:0]   pc_hw
);

    localparam int            c_IW        = $clog2(NUM_REQ);
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(NUM_REQ - 1);
    localparam logic [3:0]    c_WDOG_LAST = 4'(TIMEOUT - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_IW-1:0]     r_rr_ptr;
    logic [c_IW-1:0]     r_idx;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [c_RES_W-1:0]  r_result;
    logic                r_err_flag;
    logic [DW-1:0]       r_pc_din;
    logic [3:0]          r_wdog;

    logic [NUM_REQ-1:0]  w_arb_gnt;
    logic [c_IW-1:0]     w_arb_idx;
    logic                w_arb_any;
    logic [DW-1:0]       w_slice [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign w_slice[gi] = req_data[gi*DW +: DW];
        end
    endgenerate

    rr_arbiter_onehot #(
        .N  (NUM_REQ),
        .IW (c_IW)
    ) u_arb (
        .req (req),
        .ptr (r_rr_ptr),
        .gnt (w_arb_gnt),
        .idx (w_arb_idx),
        .any (w_arb_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // pc_vld is ignored in S_START: the unit only drops it one cycle after start
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_arb_any && pc_vld) w_state_nxt = S_START;
            S_START: w_state_nxt = S_RUN;
            S_RUN:   if (pc_vld || (r_wdog == c_WDOG_LAST)) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state != S_IDLE);
        pc_start = (r_state == S_START);
        done     = (r_state == S_DONE) ? r_gnt : '0;
        err      = (r_state == S_DONE) && r_err_flag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_idx      <= '0;
            r_gnt      <= '0;
            r_result   <= '0;
            r_err_flag <= 1'b0;
            r_pc_din   <= '0;
            r_wdog     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_arb_any && pc_vld) begin
                        r_gnt      <= w_arb_gnt;
                        r_idx      <= w_arb_idx;
                        r_pc_din   <= w_slice[w_arb_idx];
                        r_err_flag <= 1'b0;
                    end
                end
                S_START: begin
                    r_wdog <= '0;
                end
                S_RUN: begin
                    r_wdog <= r_wdog + 4'd1;
                    if (pc_vld) begin
                        r_result <= pc_hw;
                    end else if (r_wdog == c_WDOG_LAST) begin
                        r_result   <= '0;
                        r_err_flag <= 1'b1;
                    end
                end
                default: begin
                    r_gnt    <= '0;
                    r_rr_ptr <= (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
                end
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign result = r_result;
    assign pc_din = r_pc_din;

endmodule : popcnt_share_ctrl
`default_nettype wire
